ds_lane_mem: RTL and testbench
==============================

Name: ds_lane_mem

Overview:
- Parametrised successor of the single-cycle data store: byte-lane data memory with word/half/byte access and a registered read.
- Adds sign/zero extension on loads, misalignment detection, and a second registered read port for display/debug.
- Replaces the for-loop clear with a one-word-per-cycle clear sequencer, so the array infers as block RAM.
- Sits between the CPU load/store unit and the FPGA display path.

Parameters:
- AWIDTH, 12: byte-address width. Array depth is DEPTH = 2**(AWIDTH-2) words.
- DWIDTH, 32: word width, fixed at 4 byte lanes of 8 bits each. Any other value is illegal.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous active-high reset; also starts the clear sweep.
- en  in  1  access request, sampled at the clock edge.
- str  in  1  1 = store, 0 = load; valid only with en.
- mode  in  2  00 word, 01 byte, 10 half, 11 reserved.
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- address  in  AWIDTH  byte address of the access.
- data_in  in  32  store data; low-aligned (byte in [7:0], half in [15:0]).
- extra_addr  in  AWIDTH  debug read address; bits [1:0] ignored.
- data_out  out  32  registered load result, right-aligned and extended.
- rvalid  out  1  one-cycle pulse: data_out is valid.
- extra_dout  out  32  registered full word at extra_addr.
- busy  out  1  clear sweep in progress.
- misalign  out  1  one-cycle pulse: access rejected.

Behaviour:
- Reset (clr=1 at an edge):
  - data_out=0, extra_dout=0, rvalid=0, misalign=0.
  - busy=1; clear counter cnt=0; no array write.
  - Holding clr high keeps cnt at 0 and busy at 1.
  - clr asserted mid-sweep restarts the sweep from word 0.
- Clear sweep (each edge with clr=0 and busy=1):
  - Write 0 to word cnt, then cnt <= cnt+1.
  - The edge that writes word DEPTH-1 also sets busy <= 0.
  - The sweep therefore lasts exactly DEPTH cycles after clr falls.
  - en is ignored while busy: no write, no rvalid, no misalign.
- Access accept condition: edge with en=1, busy=0, clr=0.
- Misalignment (checked first):
  - Rejected cases: word with address[1:0]!=0; half with address[0]=1; mode=11.
  - Response: misalign=1 for the next cycle, rvalid=0, array unchanged.
- Store (str=1, aligned):
  - Word: all lanes <= data_in.
  - Half: lanes {2*address[1]+1, 2*address[1]} <= data_in[15:0].
  - Byte: lane address[1:0] <= data_in[7:0].
  - Other lanes are untouched. rvalid stays 0.
- Load (str=0, aligned):
  - Latency 1: the result is in data_out with rvalid=1 in the cycle after the accepting edge.
  - Selected lane(s) are shifted to bit 0 and extended to 32 bits using sext. Word loads ignore sext.
- Hold rule: data_out holds its last value except on load results. After rvalid deasserts, data_out is unchanged.
- Extra port:
  - extra_dout <= word[extra_addr[AWIDTH-1:2]] every edge, including during the sweep.
  - Read-before-write: a same-edge store or clear to the same word shows the old data.
- Lane mapping is little-endian: lane 0 holds address[1:0]=00 and data bits [7:0].
- No back-pressure: one access per cycle, and each access completes at the next edge.

Test Plan:
- Clear sweep timing: AWIDTH=4 (DEPTH=4); pulse clr for 1 cycle, then drive en=1 throughout the sweep -> busy=1 for exactly 4 cycles after clr falls, no rvalid/misalign during the sweep, all words read back 0.
- Byte store and loads: store word 0x80FF7F01 @0; load byte @3 with sext=1 -> data_out=0xFFFFFF80, rvalid 1 cycle later; same load with sext=0 -> 0x00000080.
- Half store merge: store half 0xBEEF @2 over word 0x11223344 @0 -> load word @0 = 0xBEEF3344; load half @2 with sext=1 -> 0xFFFFBEEF.
- Misalignment: word load @1, half store @3, mode=11 @0 -> misalign pulse each, rvalid=0, memory unchanged (word @0 still 0xBEEF3344).
- Clear interrupted: assert clr again on the 2nd sweep cycle -> cnt restarts at 0, busy total = 1 + DEPTH cycles from the re-assertion; extra_dout read of a written word goes 0 once swept.
- Extra-port read-before-write: store word 0xCAFEF00D @8 with extra_addr=8 on the same edge -> extra_dout shows the old value, then 0xCAFEF00D the following cycle.

Source files
------------

// File: rtl/ds_lane_mem.sv
// Byte-lane data memory: word/half/byte loads and stores with a registered read,
// sign/zero extension, misalignment rejection, a registered debug read port and
// a one-word-per-cycle clear sweep so each lane maps onto block RAM.

// One 8-bit lane: single write port, registered load port, registered debug port.
module ds_lane_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata,
    input  logic [AW-1:0] xaddr,
    output logic [7:0]    xdata
);
    logic [7:0] mem [0:(2**AW)-1];

    // Array write, kept free of reset so the array stays a plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Load read: only updates on an accepted load so data_out holds between loads.
    always_ff @(posedge clk) begin
        if (clr)     rdata <= 8'h00;
        else if (re) rdata <= mem[raddr];
    end

    // Debug read every edge; read-first so a same-edge write shows old data.
    always_ff @(posedge clk) begin
        if (clr) xdata <= 8'h00;
        else     xdata <= mem[xaddr];
    end
endmodule

module ds_lane_mem #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              str,
    input  logic [1:0]        mode,
    input  logic              sext,
    input  logic [AWIDTH-1:0] address,
    input  logic [DWIDTH-1:0] data_in,
    input  logic [AWIDTH-1:0] extra_addr,
    output logic [DWIDTH-1:0] data_out,
    output logic              rvalid,
    output logic [DWIDTH-1:0] extra_dout,
    output logic              busy,
    output logic              misalign
);
    localparam int NUM_LANES = 4;
    localparam int WW        = AWIDTH - 2;

    if (DWIDTH != 32) begin : g_bad_width
        $error("ds_lane_mem: DWIDTH must be 32");
    end

    logic [WW-1:0]                   cnt;
    logic [WW-1:0]                   widx, waddr;
    logic                            sweep, accept, bad, do_store, do_load;
    logic [NUM_LANES-1:0]            lane_sel, lane_we;
    logic [NUM_LANES-1:0][7:0]       lane_wd, lane_rd, lane_xd;
    logic [1:0]                      ld_mode, ld_off;
    logic                            ld_sext;
    logic [31:0]                     rword, shifted;
    logic                            unused_ok;

    assign widx      = address[AWIDTH-1:2];
    assign unused_ok = &{1'b0, extra_addr[1:0]};

    // Access decode: misalignment wins over everything, the sweep locks out requests.
    always_comb begin
        bad      = (mode == 2'b11) || (mode == 2'b00 && address[1:0] != 2'b00)
                || (mode == 2'b10 && address[0]);
        sweep    = busy && !clr;
        accept   = en && !busy && !clr;
        do_store = accept && !bad && str;
        do_load  = accept && !bad && !str;
        waddr    = sweep ? cnt : widx;
        case (mode)
            2'b00:   lane_sel = 4'b1111;
            2'b01:   lane_sel = 4'b0001 << address[1:0];
            2'b10:   lane_sel = address[1] ? 4'b1100 : 4'b0011;
            default: lane_sel = 4'b0000;
        endcase
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // Store data is low-aligned: bytes replicate to every lane, halves to lane pairs.
        always_comb begin
            lane_we[l] = sweep || (do_store && lane_sel[l]);
            case (mode)
                2'b01:   lane_wd[l] = data_in[7:0];
                2'b10:   lane_wd[l] = data_in[8*(l%2) +: 8];
                default: lane_wd[l] = data_in[8*l +: 8];
            endcase
            if (sweep) lane_wd[l] = 8'h00;
        end

        ds_lane_ram #(.AW(WW)) u_lane (
            .clk   (clk),
            .clr   (clr),
            .we    (lane_we[l]),
            .waddr (waddr),
            .wdata (lane_wd[l]),
            .re    (do_load),
            .raddr (widx),
            .rdata (lane_rd[l]),
            .xaddr (extra_addr[AWIDTH-1:2]),
            .xdata (lane_xd[l])
        );
    end

    // Sweep sequencer, response pulses, and load shape captured alongside the read.
    always_ff @(posedge clk) begin
        if (clr) begin
            busy     <= 1'b1;
            cnt      <= '0;
            rvalid   <= 1'b0;
            misalign <= 1'b0;
            ld_mode  <= 2'b00;
            ld_off   <= 2'b00;
            ld_sext  <= 1'b0;
        end else begin
            rvalid   <= do_load;
            misalign <= accept && bad;
            if (busy) begin
                cnt <= cnt + 1'b1;
                if (&cnt) busy <= 1'b0;
            end
            if (do_load) begin
                ld_mode <= mode;
                ld_off  <= address[1:0];
                ld_sext <= sext;
            end
        end
    end

    // Right-align the selected lanes and extend; all inputs are held registers.
    always_comb begin
        rword   = lane_rd;
        shifted = rword >> {ld_off, 3'b000};
        case (ld_mode)
            2'b01:   data_out = {{24{ld_sext & shifted[7]}}, shifted[7:0]};
            2'b10:   data_out = {{16{ld_sext & shifted[15]}}, shifted[15:0]};
            default: data_out = rword;
        endcase
    end

    assign extra_dout = lane_xd;
endmodule

// File: tb/tb_ds_lane_mem.sv
module tb_ds_lane_mem;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** (AW - 2);
    localparam int NB    = DEPTH * 4;

    logic          clk = 1'b0;
    logic          clr, en, str, sext;
    logic [1:0]    mode;
    logic [AW-1:0] address, extra_addr;
    logic [31:0]   data_in;
    logic [31:0]   data_out, extra_dout;
    logic          rvalid, busy, misalign;

    int checks = 0;
    int errors = 0;

    // Reference model: flat byte array plus the externally visible state.
    logic [7:0]  m_mem [NB];
    bit          m_busy, m_rv, m_mis;
    int          m_cnt;
    logic [31:0] m_dout, m_x;

    always #5 clk = ~clk;

    ds_lane_mem #(.AWIDTH(AW), .DWIDTH(32)) dut (
        .clk(clk), .clr(clr), .en(en), .str(str), .mode(mode), .sext(sext),
        .address(address), .data_in(data_in), .extra_addr(extra_addr),
        .data_out(data_out), .rvalid(rvalid), .extra_dout(extra_dout),
        .busy(busy), .misalign(misalign)
    );

    function automatic logic [31:0] m_word(input int w);
        return {m_mem[4*w+3], m_mem[4*w+2], m_mem[4*w+1], m_mem[4*w]};
    endfunction

    task automatic model_edge();
        logic [31:0] xw, v;
        int n, a;
        xw = m_word(int'(extra_addr) / 4);
        if (clr) begin
            m_dout = 0; m_rv = 0; m_mis = 0; m_x = 0; m_busy = 1; m_cnt = 0;
        end else begin
            m_x = xw; m_rv = 0; m_mis = 0;
            if (m_busy) begin
                for (int b = 0; b < 4; b++) m_mem[m_cnt*4+b] = 8'h00;
                m_cnt++;
                if (m_cnt == DEPTH) m_busy = 0;
            end else if (en) begin
                a = int'(address);
                n = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
                if (n == 0 || a % n != 0) m_mis = 1;
                else if (str) begin
                    for (int b = 0; b < n; b++) m_mem[a+b] = data_in[8*b +: 8];
                end else begin
                    v = 0;
                    for (int b = 0; b < n; b++) v = v | (32'(m_mem[a+b]) << (8*b));
                    if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
                    m_dout = v; m_rv = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic acc(input bit s, input logic [1:0] md, input bit sx, input int a,
                       input logic [31:0] d);
        clr = 0; en = 1; str = s; mode = md; sext = sx; address = a[AW-1:0]; data_in = d;
        tick();
        en = 0;
    endtask

    task automatic test_reset();
        clr = 1; en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (data_out !== 0 || extra_dout !== 0 || rvalid !== 0 || misalign !== 0 || busy !== 1) begin
                errors++;
                $display("FAIL reset_state got dout=%h x=%h rv=%b mis=%b busy=%b want 0 0 0 0 1",
                         data_out, extra_dout, rvalid, misalign, busy);
            end
        end
        // sweep with requests hammering
        clr = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            en = 1; str = 1'($urandom); mode = 2'($urandom); sext = 1'($urandom);
            address = AW'($urandom); data_in = $urandom;
            tick();
            checks++;
            if (busy !== (k < DEPTH) || rvalid !== 0 || misalign !== 0) begin
                errors++;
                $display("FAIL sweep_cycle%0d got busy=%b rv=%b mis=%b want busy=%b rv=0 mis=0",
                         k, busy, rvalid, misalign, k < DEPTH);
            end
        end
        en = 0;
        for (int w = 0; w < DEPTH; w++) begin
            extra_addr = AW'(4*w);
            acc(0, 2'b00, 0, 4*w, 0);
            checks++;
            if (data_out !== 0 || rvalid !== 1 || extra_dout !== 0) begin
                errors++;
                $display("FAIL swept_word%0d got dout=%h rv=%b x=%h want 0 1 0",
                         w, data_out, rvalid, extra_dout);
            end
        end
    endtask

    task automatic test_byte();
        logic [31:0] exp_v [4];
        bit          sx [4];
        int          ad [4];
        exp_v = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F, 32'h000000FF};
        sx    = '{1, 0, 1, 0};
        ad    = '{3, 3, 1, 2};
        acc(1, 2'b00, 0, 0, 32'h80FF7F01);
        checks++;
        if (rvalid !== 0) begin
            errors++; $display("FAIL store_rvalid got %b want 0", rvalid);
        end
        for (int i = 0; i < 4; i++) begin
            acc(0, 2'b01, sx[i], ad[i], $urandom);
            checks++;
            if (data_out !== exp_v[i] || rvalid !== 1) begin
                errors++;
                $display("FAIL byte_load%0d got %h rv=%b want %h rv=1", i, data_out, rvalid, exp_v[i]);
            end
        end
        tick();
        checks++;
        if (rvalid !== 0 || data_out !== 32'h000000FF) begin
            errors++;
            $display("FAIL hold_after_load got %h rv=%b want 000000ff rv=0", data_out, rvalid);
        end
    endtask

    task automatic test_half();
        acc(1, 2'b00, 0, 0, 32'h11223344);
        acc(1, 2'b10, 0, 2, 32'h5A5ABEEF);
        acc(0, 2'b00, 1, 0, 0);
        checks++;
        if (data_out !== 32'hBEEF3344 || rvalid !== 1) begin
            errors++; $display("FAIL half_merge got %h want beef3344", data_out);
        end
        acc(0, 2'b10, 1, 2, 0);
        checks++;
        if (data_out !== 32'hFFFFBEEF) begin
            errors++; $display("FAIL half_sext got %h want ffffbeef", data_out);
        end
        acc(0, 2'b10, 1, 0, 0);
        checks++;
        if (data_out !== 32'h00003344) begin
            errors++; $display("FAIL half_low got %h want 00003344", data_out);
        end
    endtask

    task automatic test_misalign();
        logic [1:0] md [3];
        bit         s  [3];
        int         ad [3];
        md = '{2'b00, 2'b10, 2'b11};
        s  = '{0, 1, 1};
        ad = '{1, 3, 0};
        for (int i = 0; i < 3; i++) begin
            acc(s[i], md[i], 1, ad[i], 32'hDEADDEAD);
            checks++;
            if (misalign !== 1 || rvalid !== 0 || data_out !== 32'h00003344) begin
                errors++;
                $display("FAIL misalign%0d got mis=%b rv=%b dout=%h want 1 0 00003344",
                         i, misalign, rvalid, data_out);
            end
            tick();
            checks++;
            if (misalign !== 0) begin
                errors++; $display("FAIL misalign_pulse%0d got %b want 0", i, misalign);
            end
        end
        acc(0, 2'b00, 0, 0, 0);
        checks++;
        if (data_out !== 32'hBEEF3344) begin
            errors++; $display("FAIL misalign_mem got %h want beef3344", data_out);
        end
    endtask

    task automatic test_clear_interrupt();
        int nbusy = 0;
        acc(1, 2'b00, 0, 12, 32'h12345678);
        extra_addr = AW'(12);
        clr = 1; tick();
        clr = 0; tick();
        clr = 1;
        if (busy) nbusy++;
        tick();
        if (busy) nbusy++;
        clr = 0;
        for (int k = 1; k <= DEPTH; k++) begin
            tick();
            if (busy) nbusy++;
            checks++;
            if (busy !== m_busy || extra_dout !== m_x) begin
                errors++;
                $display("FAIL restart_sweep%0d got busy=%b x=%h want %b %h",
                         k, busy, extra_dout, m_busy, m_x);
            end
        end
        checks++;
        if (extra_dout !== 32'h12345678) begin
            errors++; $display("FAIL sweep_rbw got %h want 12345678", extra_dout);
        end
        tick();
        checks++;
        if (extra_dout !== 0 || nbusy != 1 + DEPTH) begin
            errors++;
            $display("FAIL restart_total got x=%h busy_cycles=%0d want 0 %0d", extra_dout, nbusy, 1 + DEPTH);
        end
    endtask

    task automatic test_extra_rbw();
        extra_addr = 0;
        acc(1, 2'b00, 0, 8, 32'h01020304);
        extra_addr = AW'(8);
        acc(1, 2'b00, 0, 8, 32'hCAFEF00D);
        checks++;
        if (extra_dout !== 32'h01020304) begin
            errors++; $display("FAIL extra_rbw_old got %h want 01020304", extra_dout);
        end
        tick();
        checks++;
        if (extra_dout !== 32'hCAFEF00D) begin
            errors++; $display("FAIL extra_rbw_new got %h want cafef00d", extra_dout);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            clr = ($urandom_range(0, 79) == 0);
            en = ($urandom_range(0, 3) != 0); str = 1'($urandom); mode = 2'($urandom);
            sext = 1'($urandom); data_in = $urandom; extra_addr = AW'($urandom);
            address = AW'($urandom);
            if ($urandom_range(0, 1) == 1) address[1:0] = 2'b00;
            tick();
            checks++;
            if (data_out !== m_dout || rvalid !== m_rv || misalign !== m_mis ||
                busy !== m_busy || extra_dout !== m_x) begin
                errors++;
                $display("FAIL random%0d got dout=%h rv=%b mis=%b busy=%b x=%h want %h %b %b %b %h",
                         i, data_out, rvalid, misalign, busy, extra_dout,
                         m_dout, m_rv, m_mis, m_busy, m_x);
            end
        end
    endtask

    initial begin
        clr = 1; en = 0; str = 0; mode = 0; sext = 0;
        address = 0; extra_addr = 0; data_in = 0;
        for (int i = 0; i < NB; i++) m_mem[i] = 8'h00;
        m_busy = 1; m_cnt = 0; m_dout = 0; m_x = 0; m_rv = 0; m_mis = 0;
        test_reset();
        test_byte();
        test_half();
        test_misalign();
        test_clear_interrupt();
        test_extra_rbw();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
